// File: rtl/nexys_starship_fault_gen.sv
`default_nettype none
// ============================================================================
// Module      : nexys_starship_fault_gen
// Description : Fault initiator for the room subsystems. While play is active
//               it waits a shrinking interval, picks a room that is not
//               already broken, strikes it with a one-cycle one-hot pulse and
//               presents a non-zero 4-bit repair code on a shared bus.
// Ports       : Clk, Reset          - clock, synchronous active-high reset
//               play_flag           - start of play (level, sampled in IDLE)
//               gameover_ctrl       - end of game, forces IDLE
//               room_broken[N]      - per-room broken status
//               room_random[N]      - one-hot one-cycle strike pulse
//               random_hex[4]       - repair code, held until next strike
//               fault_count[8]      - faults issued this game, saturating
//               interval_cur[32]    - current WAIT length in cycles
//               q_Idle/q_Wait/q_Pick/q_Issue - one-hot state flags
// Revision    : 1.0 - initial release
// ============================================================================
module nexys_starship_fault_gen #(
  parameter int          NUM_ROOMS     = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic [31:0] INTERVAL_INIT = 32'd200_000_000,
  parameter logic [31:0] INTERVAL_MIN  = 32'd50_000_000,
  parameter logic [31:0] INTERVAL_STEP = 32'd10_000_000
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 play_flag,
  input  logic                 gameover_ctrl,
  input  logic [NUM_ROOMS-1:0] room_broken,
  output logic [NUM_ROOMS-1:0] room_random,
  output logic [3:0]           random_hex,
  output logic [7:0]           fault_count,
  output logic [31:0]          interval_cur,
  output logic                 q_Idle,
  output logic                 q_Wait,
  output logic                 q_Pick,
  output logic                 q_Issue
);

  localparam int PW = (NUM_ROOMS > 2) ? $clog2(NUM_ROOMS) : 1;
  localparam logic [PW-1:0] c_LAST_ROOM  = PW'(NUM_ROOMS - 1);
  localparam logic [3:0]    c_LAST_PROBE = 4'(NUM_ROOMS - 1);
  localparam logic [3:0]    c_NUM_ROOMS4 = 4'(NUM_ROOMS);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_PICK  = 2'd2,
    S_ISSUE = 2'd3
  } state_t;

  state_t                r_state;
  logic [31:0]           r_timer;
  logic [PW-1:0]         r_probe;
  logic [3:0]            r_probe_cnt;
  logic [NUM_ROOMS-1:0]  r_room;
  logic [3:0]            r_hex;
  logic [7:0]            r_count;
  logic [31:0]           r_interval;
  logic [15:0]           r_lfsr;
  logic [3:0]            r_flags;

  state_t                w_state_next;
  logic [31:0]           w_timer_next;
  logic [PW-1:0]         w_probe_next;
  logic [3:0]            w_probe_cnt_next;
  logic [NUM_ROOMS-1:0]  w_room_next;
  logic [3:0]            w_hex_next;
  logic [7:0]            w_count_next;
  logic [31:0]           w_interval_next;
  logic [15:0]           w_lfsr_next;
  logic [3:0]            w_flags_next;

  logic                  w_fb;
  logic [PW-1:0]         w_probe_seed;
  logic [NUM_ROOMS-1:0]  w_onehot;
  logic [3:0]            w_code;
  logic [31:0]           w_interval_dec;

  // Fibonacci LFSR, taps 16,14,13,11
  assign w_fb        = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign w_lfsr_next = {r_lfsr[14:0], w_fb};

  assign w_probe_seed = PW'(r_lfsr[3:0] % c_NUM_ROOMS4);
  assign w_onehot     = {{(NUM_ROOMS-1){1'b0}}, 1'b1} << r_probe;
  // A zero code would be indistinguishable from "no code", so remap it.
  assign w_code       = (r_lfsr[7:4] == 4'h0) ? 4'h1 : r_lfsr[7:4];

  // Shrink toward the floor; the first term guards against unsigned underflow.
  assign w_interval_dec = ((r_interval >= INTERVAL_STEP) &&
                           ((r_interval - INTERVAL_STEP) >= INTERVAL_MIN))
                          ? (r_interval - INTERVAL_STEP) : INTERVAL_MIN;

  always_comb begin
    w_state_next     = r_state;
    w_timer_next     = r_timer;
    w_probe_next     = r_probe;
    w_probe_cnt_next = r_probe_cnt;
    w_room_next      = '0;
    w_hex_next       = r_hex;
    w_count_next     = r_count;
    w_interval_next  = r_interval;

    if (gameover_ctrl) begin
      w_state_next = S_IDLE;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (play_flag) begin
            w_state_next    = S_WAIT;
            w_timer_next    = INTERVAL_INIT;
            w_interval_next = INTERVAL_INIT;
            w_count_next    = '0;
          end
        end
        S_WAIT: begin
          // Leaving on timer==1 makes WAIT last exactly interval_cur cycles.
          if (r_timer == 32'd1) begin
            w_state_next     = S_PICK;
            w_probe_next     = w_probe_seed;
            w_probe_cnt_next = '0;
          end else begin
            w_timer_next = r_timer - 32'd1;
          end
        end
        S_PICK: begin
          if (!room_broken[r_probe]) begin
            w_state_next    = S_ISSUE;
            w_room_next     = w_onehot;
            w_hex_next      = w_code;
            w_count_next    = (r_count == 8'hFF) ? r_count : r_count + 8'd1;
            w_interval_next = w_interval_dec;
          end else if (r_probe_cnt == c_LAST_PROBE) begin
            // Every room probed and broken: give up this round silently.
            w_state_next = S_WAIT;
            w_timer_next = r_interval;
          end else begin
            w_probe_next     = (r_probe == c_LAST_ROOM) ? '0 : r_probe + 1'b1;
            w_probe_cnt_next = r_probe_cnt + 4'd1;
          end
        end
        S_ISSUE: begin
          w_state_next = S_WAIT;
          w_timer_next = r_interval;
        end
        default: begin
          w_state_next = S_IDLE;
        end
      endcase
    end

    unique case (w_state_next)
      S_IDLE:  w_flags_next = 4'b1000;
      S_WAIT:  w_flags_next = 4'b0100;
      S_PICK:  w_flags_next = 4'b0010;
      default: w_flags_next = 4'b0001;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state     <= S_IDLE;
      r_timer     <= '0;
      r_probe     <= '0;
      r_probe_cnt <= '0;
      r_room      <= '0;
      r_hex       <= 4'h1;
      r_count     <= '0;
      r_interval  <= INTERVAL_INIT;
      r_lfsr      <= LFSR_SEED;
      r_flags     <= 4'b1000;
    end else begin
      r_state     <= w_state_next;
      r_timer     <= w_timer_next;
      r_probe     <= w_probe_next;
      r_probe_cnt <= w_probe_cnt_next;
      r_room      <= w_room_next;
      r_hex       <= w_hex_next;
      r_count     <= w_count_next;
      r_interval  <= w_interval_next;
      r_lfsr      <= w_lfsr_next;
      r_flags     <= w_flags_next;
    end
  end

  assign room_random  = r_room;
  assign random_hex   = r_hex;
  assign fault_count  = r_count;
  assign interval_cur = r_interval;
  assign q_Idle       = r_flags[3];
  assign q_Wait       = r_flags[2];
  assign q_Pick       = r_flags[1];
  assign q_Issue      = r_flags[0];

endmodule
`default_nettype wire

// File: tb/tb_nexys_starship_fault_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_nexys_starship_fault_gen
// Description : Self-checking bench for nexys_starship_fault_gen. A behavioural
//               model predicts each strike and queues it; a monitor pops and
//               compares when the DUT pulses. Scenario tasks add direct checks
//               against hand-derived constants.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_nexys_starship_fault_gen;

  localparam int          N     = 4;
  localparam logic [15:0] SEED  = 16'hACE1;
  localparam int          IINIT = 8;
  localparam int          IMIN  = 4;
  localparam int          ISTEP = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         play = 1'b0;
  logic         go = 1'b0;
  logic [N-1:0] broken = '0;
  logic [N-1:0] room_random;
  logic [3:0]   random_hex;
  logic [7:0]   fault_count;
  logic [31:0]  interval_cur;
  logic         q_Idle, q_Wait, q_Pick, q_Issue;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  nexys_starship_fault_gen #(
    .NUM_ROOMS    (N),
    .LFSR_SEED    (SEED),
    .INTERVAL_INIT(32'(IINIT)),
    .INTERVAL_MIN (32'(IMIN)),
    .INTERVAL_STEP(32'(ISTEP))
  ) dut (
    .Clk          (clk),
    .Reset        (rst),
    .play_flag    (play),
    .gameover_ctrl(go),
    .room_broken  (broken),
    .room_random  (room_random),
    .random_hex   (random_hex),
    .fault_count  (fault_count),
    .interval_cur (interval_cur),
    .q_Idle       (q_Idle),
    .q_Wait       (q_Wait),
    .q_Pick       (q_Pick),
    .q_Issue      (q_Issue)
  );

  // ---------------- reference model + scoreboard ----------------
  typedef struct {
    int          cyc;
    logic [3:0]  rr;
    logic [3:0]  hex;
    logic [7:0]  cnt;
    logic [31:0] iv;
  } exp_t;
  exp_t sbq[$];

  int          ms, mt, mp, mpc, mint;
  logic [3:0]  mflags, mrr, mhex;
  logic [7:0]  mcnt;
  logic [15:0] ml;

  always @(posedge clk) begin
    logic [15:0] l;
    cyc++;
    if (rst) begin
      ms = 0; mrr = '0; mhex = 4'h1; mcnt = '0; mint = IINIT; ml = SEED;
    end else begin
      l   = ml;
      ml  = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
      mrr = '0;
      if (go) ms = 0;
      else begin
        case (ms)
          0: if (play) begin ms = 1; mt = IINIT; mint = IINIT; mcnt = '0; end
          1: if (mt == 1) begin ms = 2; mp = int'(l[3:0]) % N; mpc = 0; end
             else mt = mt - 1;
          2: if (!broken[mp]) begin
               ms   = 3;
               mrr  = 4'(1 << mp);
               mhex = (l[7:4] == 4'h0) ? 4'h1 : l[7:4];
               if (mcnt != 8'd255) mcnt = mcnt + 8'd1;
               mint = (mint - ISTEP > IMIN) ? mint - ISTEP : IMIN;
               sbq.push_back('{cyc, mrr, mhex, mcnt, 32'(mint)});
             end else if (mpc == N - 1) begin
               ms = 1; mt = mint;
             end else begin
               mp = (mp + 1) % N; mpc = mpc + 1;
             end
          default: begin ms = 1; mt = mint; end
        endcase
      end
    end
    mflags = 4'b1000 >> ms;
  end

  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      checks++;
      if ({q_Idle, q_Wait, q_Pick, q_Issue} !== mflags) begin
        errors++;
        $display("FAIL state_flags cyc=%0d got=%b exp=%b", cyc, {q_Idle, q_Wait, q_Pick, q_Issue}, mflags);
      end
      checks++;
      if (fault_count !== mcnt || interval_cur !== 32'(mint) || random_hex !== mhex) begin
        errors++;
        $display("FAIL status cyc=%0d got cnt=%0d iv=%0d hex=%h exp cnt=%0d iv=%0d hex=%h",
                 cyc, fault_count, interval_cur, random_hex, mcnt, mint, mhex);
      end
      if (room_random !== '0) begin
        checks++;
        if (sbq.size() == 0) begin
          errors++;
          $display("FAIL unexpected_pulse cyc=%0d got=%b exp=0000", cyc, room_random);
        end else begin
          e = sbq.pop_front();
          if (e.cyc != cyc || e.rr !== room_random || e.hex !== random_hex ||
              e.cnt !== fault_count || e.iv !== interval_cur) begin
            errors++;
            $display("FAIL pulse cyc=%0d got rr=%b hex=%h cnt=%0d iv=%0d exp cyc=%0d rr=%b hex=%h cnt=%0d iv=%0d",
                     cyc, room_random, random_hex, fault_count, interval_cur,
                     e.cyc, e.rr, e.hex, e.cnt, e.iv);
          end
        end
      end else if (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        checks++;
        errors++;
        $display("FAIL missed_pulse cyc=%0d got=0000 exp=%b", cyc, sbq[0].rr);
        e = sbq.pop_front();
      end
    end
  end

  // ---------------- helpers (no comparisons) ----------------
  task automatic end_game();
    play = 1'b0; go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    @(negedge clk);
  endtask

  logic [3:0] cap_rr [2][3];
  logic [3:0] cap_hex[2][3];
  int         cap_t  [2][3];

  task automatic capture3(input int run, input int base, output int n);
    n = 0;
    for (int k = 0; k < 200 && n < 3; k++) begin
      @(negedge clk);
      if (room_random !== '0) begin
        cap_rr[run][n]  = room_random;
        cap_hex[run][n] = random_hex;
        cap_t[run][n]   = cyc - base;
        n++;
      end
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst = 1'b1; play = 1'b0; go = 1'b0; broken = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    checks++; if ({q_Idle, q_Wait, q_Pick, q_Issue} !== 4'b1000) begin errors++; $display("FAIL reset_state got=%b exp=1000", {q_Idle, q_Wait, q_Pick, q_Issue}); end
    checks++; if (room_random !== 4'b0000) begin errors++; $display("FAIL reset_rr got=%b exp=0000", room_random); end
    checks++; if (random_hex !== 4'h1) begin errors++; $display("FAIL reset_hex got=%h exp=1", random_hex); end
    checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL reset_count got=%0d exp=0", fault_count); end
    checks++; if (interval_cur !== 32'd8) begin errors++; $display("FAIL reset_interval got=%0d exp=8", interval_cur); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int e0, n;
    int pc[5], pi[5], pf[5];
    int gap_exp[4] = '{8, 6, 6, 6};
    int iv_exp[4]  = '{6, 4, 4, 4};
    broken = '0;
    play = 1'b1;
    e0 = cyc + 1;
    n = 0;
    for (int k = 0; k < 200 && n < 5; k++) begin
      @(negedge clk);
      play = 1'b0;
      if (room_random !== '0) begin
        checks++;
        if (!$onehot(room_random)) begin errors++; $display("FAIL basic_onehot got=%b exp=onehot", room_random); end
        pc[n] = cyc; pi[n] = int'(interval_cur); pf[n] = int'(fault_count);
        n++;
      end
    end
    checks++;
    if (n != 5) begin
      errors++; $display("FAIL basic_timeout got=%0d pulses exp=5", n);
    end else begin
      checks++;
      if (pc[0] - e0 != IINIT + 1) begin errors++; $display("FAIL basic_first_latency got=%0d exp=%0d", pc[0] - e0, IINIT + 1); end
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (pc[i+1] - pc[i] != gap_exp[i]) begin errors++; $display("FAIL basic_gap%0d got=%0d exp=%0d", i, pc[i+1] - pc[i], gap_exp[i]); end
        checks++;
        if (pi[i] != iv_exp[i]) begin errors++; $display("FAIL basic_interval%0d got=%0d exp=%0d", i, pi[i], iv_exp[i]); end
        checks++;
        if (pf[i] != i + 1) begin errors++; $display("FAIL basic_count%0d got=%0d exp=%0d", i, pf[i], i + 1); end
      end
    end
    end_game();
  endtask

  task automatic test_one_free();
    int n = 0;
    broken = 4'b1110;
    play = 1'b1;
    for (int k = 0; k < 300 && n < 6; k++) begin
      @(negedge clk);
      play = 1'b0;
      if (room_random !== '0) begin
        n++;
        checks++;
        if (room_random !== 4'b0001) begin errors++; $display("FAIL onefree_target got=%b exp=0001", room_random); end
        checks++;
        if (random_hex === 4'h0) begin errors++; $display("FAIL onefree_hex got=0 exp=nonzero"); end
      end
    end
    checks++;
    if (n != 6) begin errors++; $display("FAIL onefree_timeout got=%0d exp=6", n); end
    end_game();
    broken = '0;
  endtask

  task automatic test_all_broken();
    int pulses = 0, run = 0, runs = 0;
    broken = 4'b1111;
    play = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      play = 1'b0;
      if (room_random !== '0) pulses++;
      if (q_Pick) run++;
      else if (run != 0) begin
        runs++;
        checks++;
        if (run != N) begin errors++; $display("FAIL allbroken_pick_len got=%0d exp=%0d", run, N); end
        run = 0;
      end
    end
    checks++; if (pulses != 0) begin errors++; $display("FAIL allbroken_pulses got=%0d exp=0", pulses); end
    checks++; if (runs < 3) begin errors++; $display("FAIL allbroken_pick_visits got=%0d exp>=3", runs); end
    checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL allbroken_count got=%0d exp=0", fault_count); end
    checks++; if (interval_cur !== 32'd8) begin errors++; $display("FAIL allbroken_interval got=%0d exp=8", interval_cur); end
    end_game();
    broken = '0;
  endtask

  task automatic test_gameover();
    int k, pulses;
    // gameover while in PICK
    play = 1'b1;
    for (k = 0; k < 50 && !q_Pick; k++) begin @(negedge clk); play = 1'b0; end
    checks++;
    if (!q_Pick) begin errors++; $display("FAIL go_pick_timeout got=no_pick exp=pick"); end
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checks++; if ({q_Idle, q_Wait, q_Pick, q_Issue} !== 4'b1000) begin errors++; $display("FAIL go_pick_idle got=%b exp=1000", {q_Idle, q_Wait, q_Pick, q_Issue}); end
    checks++; if (room_random !== '0) begin errors++; $display("FAIL go_pick_rr got=%b exp=0000", room_random); end
    pulses = 0;
    repeat (30) begin @(negedge clk); if (room_random !== '0) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL go_pick_quiet got=%0d exp=0", pulses); end
    // gameover coincident with the ISSUE cycle
    play = 1'b1;
    for (k = 0; k < 50 && !q_Issue; k++) begin @(negedge clk); play = 1'b0; end
    checks++;
    if (!q_Issue) begin errors++; $display("FAIL go_issue_timeout got=no_issue exp=issue"); end
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    checks++; if ({q_Idle, q_Wait, q_Pick, q_Issue} !== 4'b1000) begin errors++; $display("FAIL go_issue_idle got=%b exp=1000", {q_Idle, q_Wait, q_Pick, q_Issue}); end
    checks++; if (room_random !== '0) begin errors++; $display("FAIL go_issue_rr got=%b exp=0000", room_random); end
    checks++; if (fault_count !== 8'd1) begin errors++; $display("FAIL go_issue_count got=%0d exp=1", fault_count); end
    pulses = 0;
    repeat (30) begin @(negedge clk); if (room_random !== '0) pulses++; end
    checks++; if (pulses != 0) begin errors++; $display("FAIL go_issue_quiet got=%0d exp=0", pulses); end
    checks++; if (fault_count !== 8'd1) begin errors++; $display("FAIL go_issue_count_held got=%0d exp=1", fault_count); end
  endtask

  task automatic test_reset_repeat();
    int n0, n1;
    broken = '0; go = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; play = 1'b1;
    capture3(0, cyc, n0);
    repeat (2) @(negedge clk);
    checks++;
    if (!q_Wait) begin errors++; $display("FAIL rr_midwait got=%b exp=0100", {q_Idle, q_Wait, q_Pick, q_Issue}); end
    rst = 1'b1;
    @(negedge clk);
    checks++; if ({q_Idle, q_Wait, q_Pick, q_Issue} !== 4'b1000) begin errors++; $display("FAIL rr_state got=%b exp=1000", {q_Idle, q_Wait, q_Pick, q_Issue}); end
    checks++; if (room_random !== '0) begin errors++; $display("FAIL rr_rr got=%b exp=0000", room_random); end
    checks++; if (fault_count !== 8'd0) begin errors++; $display("FAIL rr_count got=%0d exp=0", fault_count); end
    checks++; if (interval_cur !== 32'd8) begin errors++; $display("FAIL rr_interval got=%0d exp=8", interval_cur); end
    checks++; if (random_hex !== 4'h1) begin errors++; $display("FAIL rr_hex got=%h exp=1", random_hex); end
    rst = 1'b0;
    capture3(1, cyc, n1);
    checks++;
    if (n0 != 3 || n1 != 3) begin
      errors++; $display("FAIL rr_capture got=%0d,%0d exp=3,3", n0, n1);
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (cap_rr[1][i] !== cap_rr[0][i] || cap_hex[1][i] !== cap_hex[0][i] || cap_t[1][i] != cap_t[0][i]) begin
          errors++;
          $display("FAIL rr_repeat%0d got rr=%b hex=%h t=%0d exp rr=%b hex=%h t=%0d", i,
                   cap_rr[1][i], cap_hex[1][i], cap_t[1][i], cap_rr[0][i], cap_hex[0][i], cap_t[0][i]);
        end
      end
    end
    end_game();
  endtask

  task automatic test_saturation();
    int n = 0;
    broken = '0;
    play = 1'b1;
    for (int k = 0; k < 2400 && n < 300; k++) begin
      @(negedge clk);
      play = 1'b0;
      if (room_random !== '0) begin
        n++;
        if (n == 256) begin
          checks++;
          if (fault_count !== 8'd255) begin errors++; $display("FAIL sat_256 got=%0d exp=255", fault_count); end
        end
      end
    end
    checks++; if (n != 300) begin errors++; $display("FAIL sat_timeout got=%0d exp=300", n); end
    checks++; if (fault_count !== 8'd255) begin errors++; $display("FAIL sat_count got=%0d exp=255", fault_count); end
    checks++; if (interval_cur !== 32'd4) begin errors++; $display("FAIL sat_interval got=%0d exp=4", interval_cur); end
    end_game();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_one_free();
    test_all_broken();
    test_gameover();
    test_reset_repeat();
    test_saturation();
    repeat (2) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin errors++; $display("FAIL scoreboard_leftover got=%0d exp=0", sbq.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #(500_000);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/nexys_starship_fault_gen.md
Name: nexys_starship_fault_gen

Overview:
- Fault initiator for the room subsystems. While play is active, it schedules random "break" events.
- For each event it picks a room that is not currently broken, drives a one-cycle one-hot strike pulse to that room, and presents a 4-bit random repair code on a shared bus. The struck room latches the code on the pulse cycle.
- The gap between faults shrinks as play continues, which ramps difficulty.
- Sits between the top-level game controller (play_flag, gameover_ctrl) and the per-room repair FSMs (their *_broken outputs and *_random/random_hex inputs).

Parameters:
- NUM_ROOMS, 4, number of rooms served; legal range 2..8.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.
- INTERVAL_INIT, 32'd200_000_000, cycles spent in WAIT before the first fault.
- INTERVAL_MIN, 32'd50_000_000, floor for the fault interval.
- INTERVAL_STEP, 32'd10_000_000, amount the interval shrinks after each issued fault.

Ports:
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high reset
- play_flag  input  1  start of play (level; sampled in IDLE)
- gameover_ctrl  input  1  end of game; highest priority after Reset
- room_broken  input  NUM_ROOMS  bit i = room i currently broken
- room_random  output  NUM_ROOMS  one-hot, one-cycle strike pulse
- random_hex  output  4  repair code; valid on and after the strike cycle
- fault_count  output  8  faults issued this game; saturates at 255
- interval_cur  output  32  current fault interval
- q_Idle, q_Wait, q_Pick, q_Issue  output  1 each  one-hot state flags

Behaviour:
- One clock domain (Clk); reset is synchronous and active-high. All outputs are registered.
- Reset values:
  - state = IDLE
  - room_random = 0
  - random_hex = 4'h1
  - fault_count = 0
  - interval_cur = INTERVAL_INIT
  - LFSR = LFSR_SEED
- LFSR:
  - 16-bit Fibonacci, taps 16,14,13,11: feedback = l[15]^l[13]^l[12]^l[10], shift left, feedback into bit 0.
  - Advances every cycle except while Reset is asserted.
- Precedence: Reset > gameover_ctrl > normal transitions. gameover_ctrl in any state moves to IDLE next edge, clears room_random, and leaves fault_count visible until the next play start.
- IDLE:
  - room_random = 0.
  - When play_flag = 1: go to WAIT; timer = INTERVAL_INIT; interval_cur = INTERVAL_INIT; fault_count = 0.
- WAIT:
  - timer decrements each cycle.
  - When timer == 1: go to PICK; probe = lfsr[3:0] mod NUM_ROOMS; probe_cnt = 0.
  - WAIT therefore lasts exactly interval_cur cycles.
- PICK (one probe per cycle):
  - If room_broken[probe] == 0: go to ISSUE; target = probe.
  - Else: probe = (probe + 1) wrapping at NUM_ROOMS; probe_cnt increments.
  - If probe_cnt reaches NUM_ROOMS (all rooms broken): go to WAIT with timer = interval_cur. No event is issued; fault_count and interval_cur are unchanged.
- On entering ISSUE (same edge as PICK→ISSUE):
  - room_random = 1 << target.
  - random_hex = lfsr[7:4], or 4'h1 if that nibble is 0. Code 0 is never issued.
  - fault_count increments, saturating at 255.
  - interval_cur = max(INTERVAL_MIN, interval_cur − INTERVAL_STEP), computed without underflow.
- ISSUE lasts one cycle. Next edge: room_random = 0, go to WAIT with timer = new interval_cur.
- random_hex holds its value until the next ISSUE.
- Timing:
  - If play_flag is sampled at edge E0 and the target is free, room_random is high between edges E0+INTERVAL_INIT+1 and E0+INTERVAL_INIT+2.
  - Steady-state event period = interval_cur + 2 cycles, plus 1 cycle per broken room skipped.
- room_random never has more than one bit set. It is never asserted for a room whose room_broken bit was 1 in the PICK cycle that selected it.

Test Plan:
Bench parameters: NUM_ROOMS=4, INTERVAL_INIT=8, INTERVAL_MIN=4, INTERVAL_STEP=2.
1. Reset, then play_flag=1 at E0, room_broken=0 -> single one-hot pulse in cycle E0+9..E0+10; later pulses start 8, 6, 6, 6 cycles apart; interval_cur reads 6, 4, 4, 4; fault_count reads 1, 2, 3, 4.
2. room_broken=4'b1110 held -> every pulse is 4'b0001, delayed 0–3 extra cycles depending on probe start; random_hex never 0.
3. room_broken=4'b1111 -> no pulse ever; state cycles WAIT→PICK (4 cycles)→WAIT; fault_count stays 0; interval_cur stays 8.
4. gameover_ctrl asserted during PICK, and separately coincident with the ISSUE cycle -> IDLE next edge; room_random 0 from that edge on; no further pulses until play_flag is seen again.
5. Reset asserted mid-WAIT -> next edge gives state IDLE, room_random 0, fault_count 0, interval_cur 8, random_hex 4'h1; with identical stimulus after reset, the pulse sequence repeats bit-exactly.
6. Run 300 faults -> fault_count saturates at 255; interval_cur stays at 4 with no wrap.
